// File: rtl/dm.sv
// rtl/dm.sv - ECAP5-DPROC decode stage: RV32I decode into a registered ALU micro-op
//
// Purpose: accepts one instruction/PC from fetch per valid/ready handshake,
// reads rs1/rs2 combinationally from the register file, and registers a fully
// decoded micro-op for execute. A single output register gives back-pressure
// toward fetch; flush_i from execute discards the held and incoming instruction.
//
// Optional feature macro: DM_ILLEGAL_DETECT_EN
//   defined   -> unsupported encodings produce a NOP micro-op with illegal_o=1
//   undefined -> illegal_o is tied to 0, unsupported encodings become silent NOPs
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   instr_i, pc_i, input_valid_i      instruction and PC from fetch
//   input_ready_o                     decode accepts this cycle
//   flush_i                           execute redirect, discard held/incoming op
//   raddr1_o, raddr2_o                register file read addresses (comb)
//   rdata1_i, rdata2_i                register file read data (comb)
//   alu_operand1_o, alu_operand2_o    ALU operands
//   alu_op_o, alu_sub_o               ALU function (funct3) and subtract select
//   alu_shift_left_o                  shift direction
//   alu_signed_shift_o                arithmetic right shift
//   result_write_o, result_addr_o     writeback enable and destination register
//   branch_cond_o, branch_offset_o    branch condition and offset bits [20:1]
//   pc_o                              PC of the decoded instruction
//   illegal_o                         unsupported instruction
//   output_valid_o, output_ready_i    micro-op handshake toward execute

module dm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic        flush_i,
  output logic [4:0]  raddr1_o,
  output logic [4:0]  raddr2_o,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  output logic [31:0] alu_operand1_o,
  output logic [31:0] alu_operand2_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_sub_o,
  output logic        alu_shift_left_o,
  output logic        alu_signed_shift_o,
  output logic        result_write_o,
  output logic [4:0]  result_addr_o,
  output logic [2:0]  branch_cond_o,
  output logic [19:0] branch_offset_o,
  output logic [31:0] pc_o,
  output logic        illegal_o,
  output logic        output_valid_o,
  input  logic        output_ready_i
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [19:0] off_b;
  logic [19:0] off_j;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign rd       = instr_i[11:7];
  assign raddr1_o = instr_i[19:15];
  assign raddr2_o = instr_i[24:20];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u = {instr_i[31:12], 12'b0};
  // Offsets are kept as bits [20:1] only; bit 0 is always zero.
  assign off_b = {{8{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
  assign off_j = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};

  logic [31:0] dec_op1, dec_op2;
  logic [2:0]  dec_alu_op, dec_cond;
  logic        dec_sub, dec_sl, dec_ss, dec_wr, dec_ill;
  logic [19:0] dec_off;
  logic [4:0]  dec_addr;

  always_comb begin
    dec_op1    = '0;
    dec_op2    = '0;
    dec_alu_op = 3'b000;
    dec_sub    = 1'b0;
    dec_sl     = 1'b0;
    dec_ss     = 1'b0;
    dec_wr     = 1'b0;
    dec_cond   = 3'b000;
    dec_off    = '0;
    dec_ill    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_op1 = imm_u;
        dec_wr  = (rd != 5'd0);
      end
      OPC_AUIPC: begin
        dec_op1 = pc_i;
        dec_op2 = imm_u;
        dec_wr  = (rd != 5'd0);
      end
      OPC_JAL: begin
        dec_op1  = pc_i;
        dec_op2  = 32'd4;
        dec_cond = 3'b001;
        dec_off  = off_j;
        dec_wr   = (rd != 5'd0);
      end
      OPC_BRANCH: begin
        if (funct3[2:1] == 2'b01) begin
          dec_ill = 1'b1;
        end else begin
          dec_op1  = rdata1_i;
          dec_op2  = rdata2_i;
          // BEQ/BNE map to 010/011; the signed/unsigned compares keep funct3.
          dec_cond = funct3[2] ? funct3 : {2'b01, funct3[0]};
          dec_off  = off_b;
        end
      end
      OPC_OP_IMM: begin
        dec_op1    = rdata1_i;
        dec_op2    = imm_i;
        dec_alu_op = funct3;
        dec_sl     = (funct3 == 3'b001);
        dec_ss     = (funct3 == 3'b101) & instr_i[30];
        dec_wr     = (rd != 5'd0);
      end
      OPC_OP: begin
        dec_op1    = rdata1_i;
        dec_op2    = rdata2_i;
        dec_alu_op = funct3;
        dec_sub    = (funct3 == 3'b000) & instr_i[30];
        dec_sl     = (funct3 == 3'b001);
        dec_ss     = (funct3 == 3'b101) & instr_i[30];
        dec_wr     = (rd != 5'd0);
      end
      default: dec_ill = 1'b1;
    endcase
    dec_addr = dec_ill ? 5'd0 : rd;
  end

  logic        capture;
  logic        valid_d, valid_q;
  logic [31:0] op1_d, op1_q, op2_d, op2_q, pc_d, pc_q;
  logic [2:0]  alu_op_d, alu_op_q, cond_d, cond_q;
  logic        sub_d, sub_q, sl_d, sl_q, ss_d, ss_q, wr_d, wr_q, ill_d, ill_q;
  logic [4:0]  addr_d, addr_q;
  logic [19:0] off_d, off_q;

  assign input_ready_o = flush_i | ~valid_q | output_ready_i;
  assign capture       = input_valid_i & input_ready_o & ~flush_i;

  always_comb begin
    valid_d  = valid_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    pc_d     = pc_q;
    alu_op_d = alu_op_q;
    cond_d   = cond_q;
    sub_d    = sub_q;
    sl_d     = sl_q;
    ss_d     = ss_q;
    wr_d     = wr_q;
    ill_d    = ill_q;
    addr_d   = addr_q;
    off_d    = off_q;
    if (output_ready_i | flush_i) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      valid_d  = 1'b1;
      op1_d    = dec_op1;
      op2_d    = dec_op2;
      pc_d     = pc_i;
      alu_op_d = dec_alu_op;
      cond_d   = dec_cond;
      sub_d    = dec_sub;
      sl_d     = dec_sl;
      ss_d     = dec_ss;
      wr_d     = dec_wr;
      addr_d   = dec_addr;
      off_d    = dec_off;
`ifdef DM_ILLEGAL_DETECT_EN
      ill_d    = dec_ill;
`else
      ill_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      pc_q     <= '0;
      alu_op_q <= '0;
      cond_q   <= '0;
      sub_q    <= 1'b0;
      sl_q     <= 1'b0;
      ss_q     <= 1'b0;
      wr_q     <= 1'b0;
      ill_q    <= 1'b0;
      addr_q   <= '0;
      off_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      pc_q     <= pc_d;
      alu_op_q <= alu_op_d;
      cond_q   <= cond_d;
      sub_q    <= sub_d;
      sl_q     <= sl_d;
      ss_q     <= ss_d;
      wr_q     <= wr_d;
      ill_q    <= ill_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
    end
  end

  assign output_valid_o     = valid_q;
  assign alu_operand1_o     = op1_q;
  assign alu_operand2_o     = op2_q;
  assign pc_o               = pc_q;
  assign alu_op_o           = alu_op_q;
  assign branch_cond_o      = cond_q;
  assign alu_sub_o          = sub_q;
  assign alu_shift_left_o   = sl_q;
  assign alu_signed_shift_o = ss_q;
  assign result_write_o     = wr_q;
  assign result_addr_o      = addr_q;
  assign branch_offset_o    = off_q;
  assign illegal_o          = ill_q;

endmodule

// File: tb/tb_dm.sv
// tb/tb_dm.sv - self-checking scoreboard bench for the dm decode stage
module tb_dm;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i, pc_i, rdata1_i, rdata2_i;
  logic        input_valid_i, input_ready_o, flush_i;
  logic [4:0]  raddr1_o, raddr2_o;
  logic [31:0] alu_operand1_o, alu_operand2_o, pc_o;
  logic [2:0]  alu_op_o, branch_cond_o;
  logic        alu_sub_o, alu_shift_left_o, alu_signed_shift_o;
  logic        result_write_o, illegal_o, output_valid_o, output_ready_i;
  logic [4:0]  result_addr_o;
  logic [19:0] branch_offset_o;

`ifdef DM_ILLEGAL_DETECT_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  dm dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o), .flush_i(flush_i),
    .raddr1_o(raddr1_o), .raddr2_o(raddr2_o), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .alu_operand1_o(alu_operand1_o), .alu_operand2_o(alu_operand2_o), .alu_op_o(alu_op_o),
    .alu_sub_o(alu_sub_o), .alu_shift_left_o(alu_shift_left_o),
    .alu_signed_shift_o(alu_signed_shift_o), .result_write_o(result_write_o),
    .result_addr_o(result_addr_o), .branch_cond_o(branch_cond_o),
    .branch_offset_o(branch_offset_o), .pc_o(pc_o), .illegal_o(illegal_o),
    .output_valid_o(output_valid_o), .output_ready_i(output_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, rd1, rd2, op1, op2;
    logic [2:0]  alu_op;
    logic        sub, sl, ss, wr;
    logic [4:0]  addr;
    logic [2:0]  cond;
    logic [19:0] off;
    logic        ill;
  } vec_t;

  vec_t tbl[13];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, pc, rd1, rd2, op1, op2,
                              input logic [2:0] alu_op, input logic sub, sl, ss, wr,
                              input logic [4:0] addr, input logic [2:0] cond,
                              input logic [19:0] off, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.op1 = op1; v.op2 = op2;
    v.alu_op = alu_op; v.sub = sub; v.sl = sl; v.ss = ss; v.wr = wr; v.addr = addr;
    v.cond = cond; v.off = off; v.ill = ill;
    return v;
  endfunction

  function automatic logic [63:0] ctrl_vec();
    return {28'd0, alu_op_o, alu_sub_o, alu_shift_left_o, alu_signed_shift_o,
            result_write_o, result_addr_o, branch_cond_o, branch_offset_o, illegal_o};
  endfunction

  task automatic compare(input vec_t e);
    check("pc", pc_o, e.pc);
    check("op1", alu_operand1_o, e.op1);
    check("op2", alu_operand2_o, e.op2);
    check("cond", branch_cond_o, e.cond);
    check("wr", result_write_o, e.wr);
    check("illegal", illegal_o, e.ill);
    if (e.cond < 3'd2) begin
      check("alu_op", alu_op_o, e.alu_op);
      check("sub", alu_sub_o, e.sub);
      check("shl", alu_shift_left_o, e.sl);
      check("sra", alu_signed_shift_o, e.ss);
    end
    if (e.wr) check("addr", result_addr_o, e.addr);
    if (e.cond != 3'd0) check("offset", branch_offset_o, e.off);
  endtask

  logic        stall_prev = 1'b0;
  logic [31:0] s_op1, s_op2, s_pc;
  logic [63:0] s_ctrl;

  always @(negedge clk) begin
    if (rst_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_op1", alu_operand1_o, s_op1);
        check("stall_op2", alu_operand2_o, s_op2);
        check("stall_pc", pc_o, s_pc);
        check("stall_ctrl", ctrl_vec(), s_ctrl);
        check("stall_valid", output_valid_o, 1'b1);
      end
      if (output_valid_o && !output_ready_i && !flush_i)
        check("stall_in_ready", input_ready_o, 1'b0);
      if (output_valid_o && flush_i) begin
        check("flush_in_ready", input_ready_o, 1'b1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (output_valid_o && output_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_output", 1'b1, 1'b0);
        else compare(exp_q.pop_front());
      end
      stall_prev = output_valid_o && !output_ready_i && !flush_i;
      s_op1  = alu_operand1_o;
      s_op2  = alu_operand2_o;
      s_pc   = pc_o;
      s_ctrl = ctrl_vec();
    end
  end

  task automatic send(input int idx);
    int guard = 0;
    instr_i = tbl[idx].instr;
    pc_i = tbl[idx].pc;
    rdata1_i = tbl[idx].rd1;
    rdata2_i = tbl[idx].rd2;
    input_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (input_ready_o && !flush_i) begin
        exp_q.push_back(tbl[idx]);
        break;
      end
      guard++;
      if (guard > 30) begin
        check("send_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk);
    #1;
    input_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, output_valid_o, 1'b0);
    check({tag, "_in_ready"}, input_ready_o, 1'b1);
    check({tag, "_op1"}, alu_operand1_o, 32'd0);
    check({tag, "_op2"}, alu_operand2_o, 32'd0);
    check({tag, "_pc"}, pc_o, 32'd0);
    check({tag, "_ctrl"}, ctrl_vec(), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    tbl[0]  = mk(32'hFFF10093, 32'h000, 32'd5, 32'h77, 32'd5, 32'hFFFFFFFF, 3'd0, 0, 0, 0, 1, 5'd1, 3'd0, 20'h0, 0);
    tbl[1]  = mk(32'hFE209CE3, 32'h100, 32'd7, 32'd9, 32'd7, 32'd9, 3'd0, 0, 0, 0, 0, 5'd0, 3'd3, 20'hFFFFC, 0);
    tbl[2]  = mk(32'h405201B3, 32'h104, 32'd10, 32'd3, 32'd10, 32'd3, 3'd0, 1, 0, 0, 1, 5'd3, 3'd0, 20'h0, 0);
    tbl[3]  = mk(32'h123453B7, 32'h108, 32'hDEAD, 32'hBEEF, 32'h12345000, 32'd0, 3'd0, 0, 0, 0, 1, 5'd7, 3'd0, 20'h0, 0);
    tbl[4]  = mk(32'hABCDE417, 32'h200, 32'd1, 32'd2, 32'h200, 32'hABCDE000, 3'd0, 0, 0, 0, 1, 5'd8, 3'd0, 20'h0, 0);
    tbl[5]  = mk(32'h010000EF, 32'h300, 32'd1, 32'd2, 32'h300, 32'd4, 3'd0, 0, 0, 0, 1, 5'd1, 3'd1, 20'h8, 0);
    tbl[6]  = mk(32'h40355493, 32'h304, 32'h80000000, 32'd2, 32'h80000000, 32'h403, 3'd5, 0, 0, 1, 1, 5'd9, 3'd0, 20'h0, 0);
    tbl[7]  = mk(32'h00D615B3, 32'h308, 32'd1, 32'd4, 32'd1, 32'd4, 3'd1, 0, 1, 0, 1, 5'd11, 3'd0, 20'h0, 0);
    tbl[8]  = mk(32'h00000013, 32'h30C, 32'd0, 32'h55, 32'd0, 32'd0, 3'd0, 0, 0, 0, 0, 5'd0, 3'd0, 20'h0, 0);
    tbl[9]  = mk(32'h00000073, 32'h310, 32'h11, 32'h22, 32'd0, 32'd0, 3'd0, 0, 0, 0, 0, 5'd0, 3'd0, 20'h0, ILL);
    tbl[10] = mk(32'h00002063, 32'h314, 32'd3, 32'd4, 32'd0, 32'd0, 3'd0, 0, 0, 0, 0, 5'd0, 3'd0, 20'h0, ILL);
    tbl[11] = mk(32'h00012083, 32'h318, 32'h1000, 32'd4, 32'd0, 32'd0, 3'd0, 0, 0, 0, 0, 5'd0, 3'd0, 20'h0, ILL);
    tbl[12] = mk(32'h0020F263, 32'h31C, 32'd1, 32'd2, 32'd1, 32'd2, 3'd0, 0, 0, 0, 0, 5'd0, 3'd7, 20'h2, 0);

    rst_i = 1'b1;
    instr_i = 32'hFFF10093;
    pc_i = '0;
    rdata1_i = '0;
    rdata2_i = '0;
    input_valid_i = 1'b0;
    flush_i = 1'b0;
    output_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    check("raddr1", raddr1_o, 5'd2);
    check("raddr2", raddr2_o, 5'd31);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    t0 = cyc;
    for (int i = 0; i < 13; i++) send(i);
    check("throughput_cycles", cyc - t0, 13);
    drain();

    output_ready_i = 1'b0;
    send(2);
    fork
      send(3);
      begin
        repeat (3) @(posedge clk);
        #1;
        output_ready_i = 1'b1;
      end
    join
    check("bp_next_valid", output_valid_o, 1'b1);
    check("bp_next_pc", pc_o, tbl[3].pc);
    drain();

    output_ready_i = 1'b0;
    send(6);
    check("flush_pre_valid", output_valid_o, 1'b1);
    instr_i = tbl[7].instr;
    pc_i = tbl[7].pc;
    input_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    input_valid_i = 1'b0;
    check("flush_valid_after", output_valid_o, 1'b0);
    check("flush_queue", exp_q.size(), 0);
    output_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("flush_no_output", output_valid_o, 1'b0);

    output_ready_i = 1'b0;
    send(4);
    check("rst_pre_valid", output_valid_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check_cleared("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    output_ready_i = 1'b1;
    send(9);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm.md
# dm

Decode stage of the ECAP5-DPROC pipeline, directly downstream of the instruction fetch module. It accepts one fetched instruction and its PC per valid/ready handshake and reads the two source registers from the register file. It registers a fully decoded micro-operation (ALU operands, ALU controls, writeback target, branch condition and 20-bit offset) for the execute stage. A single output register provides back-pressure toward fetch and supports a flush from execute.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous active-high reset
- instr_i  in  32  instruction from fetch
- pc_i  in  32  address of instr_i
- input_valid_i  in  1  fetch presents instr_i/pc_i
- input_ready_o  out  1  decode accepts this cycle
- flush_i  in  1  execute took a branch; discard held and incoming instruction
- raddr1_o  out  5  register file read address 1, comb from instr_i[19:15]
- raddr2_o  out  5  register file read address 2, comb from instr_i[24:20]
- rdata1_i  in  32  combinational read data for raddr1_o
- rdata2_i  in  32  combinational read data for raddr2_o
- alu_operand1_o  out  32  first ALU operand
- alu_operand2_o  out  32  second ALU operand
- alu_op_o  out  3  ALU function, RV32I funct3 encoding
- alu_sub_o  out  1  subtract instead of add
- alu_shift_left_o  out  1  shift direction
- alu_signed_shift_o  out  1  arithmetic right shift
- result_write_o  out  1  write result to register file
- result_addr_o  out  5  destination register
- branch_cond_o  out  3  000 none, 001 always, 010 BEQ, 011 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- branch_offset_o  out  20  byte offset bits [20:1], matches fetch boffset_i
- pc_o  out  32  PC of decoded instruction
- illegal_o  out  1  unsupported instruction (see Configuration)
- output_valid_o  out  1  decoded micro-op valid
- output_ready_i  in  1  execute consumes micro-op

## Operation
- input_ready_o = flush_i | ~output_valid_o | output_ready_i (combinational).
- Capture when input_valid_i & input_ready_o & ~flush_i. All outputs load from the decode of instr_i, pc_i and rdata1_i/rdata2_i.
- Immediates: I=sext(instr[31:20]); U={instr[31:12],12'b0}; B and J sign-extended per RV32I, with bits [20:1] driven to branch_offset_o.
- LUI: op1=imm_u, op2=0, alu_op=000.
- AUIPC: op1=pc, op2=imm_u, alu_op=000.
- JAL: op1=pc, op2=4, alu_op=000, branch_cond=001, offset=imm_j[20:1].
- BRANCH (funct3 000/001/100/101/110/111): op1=rs1, op2=rs2, cond=funct3 mapped to 010..111, offset=imm_b[20:1], no writeback. funct3 010/011 are illegal.
- OP-IMM: op1=rs1, op2=imm_i, alu_op=funct3. shift_left=(funct3==001). signed_shift=(funct3==101)&instr[30].
- OP: op1=rs1, op2=rs2, alu_op=funct3, sub=(funct3==000)&instr[30], shift flags as OP-IMM.
- result_write_o=1 for LUI/AUIPC/JAL/OP/OP-IMM when rd≠0; result_addr_o=instr[11:7].
- This revision flags LOAD, STORE, JALR, FENCE and SYSTEM as illegal.
- Illegal/NOP micro-op: operands 0, alu_op 000, all flags 0, result_write 0, branch_cond 000.

## Timing
- Reset: every output 0, input_ready_o 1, output_valid_o 0.
- Latency: one cycle from input handshake to output_valid_o.
- Throughput: one instruction per cycle while output_ready_i=1.
- Stall: output_valid_o=1 & output_ready_i=0 holds every output stable and drops input_ready_o.
- output_valid_o next = capture ? 1 : (output_ready_i | flush_i) ? 0 : hold.
- flush_i has priority over capture and over hold; output_valid_o is 0 the cycle after a flush.
- Reset asserted mid-stall clears output_valid_o immediately (asynchronous).

## Configuration
- DM_ILLEGAL_DETECT_EN defined: unsupported encodings capture a NOP micro-op with illegal_o=1 and output_valid_o=1.
- Not defined: illegal_o is tied to 0; unsupported encodings capture a NOP silently.

## Test plan
- Reset mid-operation: assert rst_i while output_valid_o=1 -> all outputs 0 that cycle; input_ready_o=1.
- Throughput: send ADDI x1,x2,-1 (0xFFF10093) with rdata1_i=5 -> next cycle op1=5, op2=0xFFFFFFFF, alu_op=000, result_write=1, result_addr=1.
- Branch: send BNE at pc=0x100 with offset -8 (0xFE209CE3) -> branch_cond=011, branch_offset_o=0xFFFFC, result_write=0.
- Back-pressure: hold output_ready_i=0 for 3 cycles with a SUB queued -> outputs stable, input_ready_o=0; release -> SUB consumed, next instruction captured the same edge.
- Flush: assert flush_i with input_valid_i=1 and output_valid_o=1 -> output_valid_o=0 next cycle; the incoming instruction is never output.
- Illegal: send 0x00000073 (ECALL) -> with DM_ILLEGAL_DETECT_EN defined, illegal_o=1 and NOP; without it, illegal_o=0 and NOP.
